// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column drive, whole-scan debounce, ghost rejection, press/release/repeat events.
// Events appear 1 cycle after scan_done (2 cycles after the last column sample); no backpressure, pulses are one cycle.
module keypad_scanner #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 10,
   parameter int REPEAT_EN      = 0,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_RATE    = 10,
   localparam int KW            = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] LINE,
   output logic [COLS-1:0] COLLUMMN,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_press,
   output logic            key_release,
   output logic            multi_key
);

   localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CLW = $clog2(COLS);
   localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
   localparam int RW  = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
   localparam int TW  = (REPEAT_RATE > 0) ? $clog2(REPEAT_RATE + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEB,
      S_PRESSED,
      S_REL
   } state_t;

   logic [DW-1:0]   dwell;
   logic [CLW-1:0]  col;
   logic [ROWS-1:0] samp [COLS];
   logic            scan_pend;
   logic            scan_done;
   logic            scan_one;
   logic            scan_multi;
   logic [KW-1:0]   scan_idx;

   logic            seen;
   logic            many;
   logic [KW-1:0]   low_idx;

   assign COLLUMMN = ~(COLS'(1) << col);

   // Row-major walk so the first hit is the lowest row*COLS+col index.
   always_comb begin
      seen    = 1'b0;
      many    = 1'b0;
      low_idx = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (samp[c][r]) begin
               if (seen) begin
                  many = 1'b1;
               end else begin
                  seen    = 1'b1;
                  low_idx = KW'(r*COLS + c);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell      <= '0;
         col        <= '0;
         scan_pend  <= 1'b0;
         scan_done  <= 1'b0;
         scan_one   <= 1'b0;
         scan_multi <= 1'b0;
         scan_idx   <= '0;
         multi_key  <= 1'b0;
         for (int c = 0; c < COLS; c++) begin
            samp[c] <= '0;
         end
      end else begin
         scan_pend <= 1'b0;
         scan_done <= 1'b0;
         if (dwell == DW'(SCAN_DIV - 1)) begin
            dwell     <= '0;
            samp[col] <= ~LINE;
            if (col == CLW'(COLS - 1)) begin
               col       <= '0;
               scan_pend <= 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            dwell <= dwell + 1'b1;
         end
         if (scan_pend) begin
            scan_done  <= 1'b1;
            scan_one   <= seen & ~many;
            scan_multi <= many;
            scan_idx   <= low_idx;
         end
         if (scan_done) begin
            multi_key <= scan_multi;
         end
      end
   end

   state_t        state, state_n;
   logic [KW-1:0] cand, cand_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [KW-1:0] code_n;
   logic          valid_n;
   logic          press_n;
   logic          rel_n;
   logic [RW-1:0] rep_cnt, rep_n;
   logic [TW-1:0] rate_cnt, rate_n;
   logic          hit_code;

   assign hit_code = scan_one && (scan_idx == key_code);

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      code_n  = key_code;
      valid_n = key_valid;
      press_n = 1'b0;
      rel_n   = 1'b0;
      rep_n   = rep_cnt;
      rate_n  = rate_cnt;
      if (scan_done) begin
         case (state)
            S_IDLE: begin
               if (scan_one) begin
                  cand_n = scan_idx;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_n = S_PRESSED;
                     code_n  = scan_idx;
                     valid_n = 1'b1;
                     press_n = 1'b1;
                     rep_n   = '0;
                     rate_n  = '0;
                     cnt_n   = '0;
                  end else begin
                     state_n = S_DEB;
                     cnt_n   = CW'(1);
                  end
               end
            end
            S_DEB: begin
               if (!scan_one) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (scan_idx == cand) begin
                  if (cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                     state_n = S_PRESSED;
                     code_n  = cand;
                     valid_n = 1'b1;
                     press_n = 1'b1;
                     rep_n   = '0;
                     rate_n  = '0;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cand_n = scan_idx;
                  cnt_n  = CW'(1);
               end
            end
            S_PRESSED: begin
               if (hit_code) begin
                  // rep_cnt saturates at the delay; rate_cnt then paces the repeats.
                  if (rep_cnt < RW'(REPEAT_DELAY)) begin
                     rep_n = rep_cnt + 1'b1;
                     if (rep_n == RW'(REPEAT_DELAY) && REPEAT_EN != 0) begin
                        press_n = 1'b1;
                     end
                  end else if (rate_cnt == TW'(REPEAT_RATE - 1)) begin
                     rate_n = '0;
                     if (REPEAT_EN != 0) begin
                        press_n = 1'b1;
                     end
                  end else begin
                     rate_n = rate_cnt + 1'b1;
                  end
               end else if (DEBOUNCE_SCANS == 1) begin
                  state_n = S_IDLE;
                  valid_n = 1'b0;
                  rel_n   = 1'b1;
               end else begin
                  state_n = S_REL;
                  cnt_n   = CW'(1);
               end
            end
            S_REL: begin
               if (hit_code) begin
                  state_n = S_PRESSED;
                  cnt_n   = '0;
               end else if (cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                  state_n = S_IDLE;
                  valid_n = 1'b0;
                  rel_n   = 1'b1;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cand        <= '0;
         cnt         <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         rep_cnt     <= '0;
         rate_cnt    <= '0;
      end else begin
         state       <= state_n;
         cand        <= cand_n;
         cnt         <= cnt_n;
         key_code    <= code_n;
         key_valid   <= valid_n;
         key_press   <= press_n;
         key_release <= rel_n;
         rep_cnt     <= rep_n;
         rate_cnt    <= rate_n;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a plain and an auto-repeat instance share one simulated keypad.
// Expected events carry the scan number and cycle offset at which they must appear.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pressed;

   logic [3:0] line_a, col_a, code_a;
   logic [3:0] line_b, col_b, code_b;
   logic       valid_a, press_a, rel_a, multi_a;
   logic       valid_b, press_b, rel_b, multi_b;

   always #5 clk = ~clk;

   keypad_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
      .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut (
      .clk(clk), .rst(rst), .LINE(line_a), .COLLUMMN(col_a),
      .key_code(code_a), .key_valid(valid_a), .key_press(press_a),
      .key_release(rel_a), .multi_key(multi_a)
   );

   keypad_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
      .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut_r (
      .clk(clk), .rst(rst), .LINE(line_b), .COLLUMMN(col_b),
      .key_code(code_b), .key_valid(valid_b), .key_press(press_b),
      .key_release(rel_b), .multi_key(multi_b)
   );

   // Keypad model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      line_a = 4'hF;
      line_b = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!col_a[c] && pressed[r*4+c]) line_a[r] = 1'b0;
            if (!col_b[c] && pressed[r*4+c]) line_b[r] = 1'b0;
         end
      end
   end

   typedef struct packed {
      logic        rel;
      logic [3:0]  code;
      logic [15:0] scan;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_vec = 0;
   int n_bad = 0;
   int scan_no = 0;
   int cyc = 0;
   logic [3:0] prev_col = 4'hE;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic exp_evt(input int which, input logic rel, input logic [3:0] code, input int scan);
      exp_t e;
      e.rel  = rel;
      e.code = code;
      e.scan = scan[15:0];
      if (which[0]) q0.push_back(e);
      if (which[1]) q1.push_back(e);
   endtask

   task automatic mon(input int d, input logic p, input logic r, input logic [3:0] code);
      exp_t e;
      int   sz;
      if (p && r) begin
         n_vec++;
         n_bad++;
         $display("FAIL press_and_release dut%0d: both pulses high at scan %0d, required exclusive", d, scan_no);
      end
      if (p || r) begin
         n_vec++;
         sz = (d == 0) ? q0.size() : q1.size();
         if (sz == 0) begin
            n_bad++;
            $display("FAIL unexpected_event dut%0d: got rel=%0d code=%0d at scan %0d cyc %0d, required no event",
                     d, r, code, scan_no, cyc);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.rel != r || e.code != code || e.scan != scan_no[15:0] || cyc != 2) begin
               n_bad++;
               $display("FAIL event dut%0d: got rel=%0d code=%0d scan=%0d cyc=%0d, required rel=%0d code=%0d scan=%0d cyc=2",
                        d, r, code, scan_no, cyc, e.rel, e.code, e.scan);
            end
         end
      end
   endtask

   // Monitor: tracks scan boundaries from the column wrap and pops the scoreboard on every event pulse.
   always @(posedge clk) begin
      #1;
      if (col_a == 4'hE && prev_col == 4'h7) begin
         scan_no++;
         cyc = 0;
      end else begin
         cyc++;
      end
      prev_col = col_a;
      chk("one_cold_a", $countones(~col_a), 1);
      chk("one_cold_b", $countones(~col_b), 1);
      mon(0, press_a, rel_a, code_a);
      mon(1, press_b, rel_b, code_b);
   end

   task automatic hold(input logic [15:0] m, input int n);
      pressed = m;
      for (int i = 0; i < n; i++) begin
         int target;
         int t;
         target = scan_no + 1;
         t = 0;
         while (scan_no < target && t < 40) begin
            @(posedge clk);
            #3;
            t++;
         end
         if (scan_no < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL scan_timeout: got scan %0d, required %0d", scan_no, target);
         end
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #3;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_col_a"},   col_a,   4'hE);
      chk({tag, "_col_b"},   col_b,   4'hE);
      chk({tag, "_code_a"},  code_a,  0);
      chk({tag, "_code_b"},  code_b,  0);
      chk({tag, "_valid_a"}, valid_a, 0);
      chk({tag, "_valid_b"}, valid_b, 0);
      chk({tag, "_press_a"}, press_a, 0);
      chk({tag, "_rel_a"},   rel_a,   0);
      chk({tag, "_multi_a"}, multi_a, 0);
      chk({tag, "_multi_b"}, multi_b, 0);
   endtask

   initial begin
      int s;
      logic [3:0] col_req;
      rst = 1'b1;
      pressed = '0;
      repeat (3) @(posedge clk);
      #3;
      chk_reset("reset");
      rst = 1'b0;

      // Idle scan: column walks 1110 -> 1101 -> 1011 -> 0111, 4 cycles each.
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #3;
         col_req = ~(4'b0001 << ((i / 4) % 4));
         chk("idle_col", col_a, col_req);
      end
      chk("idle_valid", valid_a, 0);
      chk("idle_multi", multi_a, 0);
      chk("idle_scan_count", scan_no, 1);

      // Single press of row 1 col 2 (key 6) for 6 scans.
      s = scan_no;
      exp_evt(3, 1'b0, 4'd6, s + 3);
      exp_evt(3, 1'b1, 4'd6, s + 9);
      hold(16'h0040, 6);
      chk("press_valid", valid_a, 1);
      chk("press_code", code_a, 6);
      hold(16'h0000, 3);
      hold(16'h0000, 1);
      chk("release_valid", valid_a, 0);
      chk("release_code_held", code_a, 6);

      // Bounce on key 5: 2 scans, gap, then 3 scans.
      s = scan_no;
      exp_evt(3, 1'b0, 4'd5, s + 6);
      exp_evt(3, 1'b1, 4'd5, s + 9);
      hold(16'h0020, 2);
      hold(16'h0000, 1);
      hold(16'h0020, 3);
      settle();
      chk("bounce_valid", valid_a, 1);
      chk("bounce_code", code_a, 5);
      hold(16'h0020, 0);
      hold(16'h0000, 3);
      hold(16'h0000, 1);

      // Ghost: keys 0 and 15 together.
      hold(16'h8001, 1);
      settle();
      chk("ghost_multi_a", multi_a, 1);
      chk("ghost_multi_b", multi_b, 1);
      chk("ghost_valid_first", valid_a, 0);
      hold(16'h8001, 4);
      chk("ghost_valid", valid_a, 0);
      chk("ghost_multi_held", multi_a, 1);
      hold(16'h0000, 1);
      settle();
      chk("ghost_multi_clear", multi_a, 0);

      // Auto-repeat on key 9: plain instance presses once, repeat instance at rep_cnt 4,6,8,10,12.
      s = scan_no;
      exp_evt(3, 1'b0, 4'd9, s + 3);
      for (int k = 7; k <= 15; k += 2) exp_evt(2, 1'b0, 4'd9, s + k);
      exp_evt(3, 1'b1, 4'd9, s + 18);
      hold(16'h0200, 15);
      chk("repeat_valid_b", valid_b, 1);
      chk("repeat_code_b", code_b, 9);
      hold(16'h0000, 3);
      hold(16'h0000, 1);
      chk("repeat_release_b", valid_b, 0);

      // Reset while key 3 is held and accepted.
      s = scan_no;
      exp_evt(3, 1'b0, 4'd3, s + 3);
      hold(16'h0008, 4);
      chk("pre_reset_valid_a", valid_a, 1);
      chk("pre_reset_valid_b", valid_b, 1);
      rst = 1'b1;
      @(posedge clk);
      #3;
      chk_reset("midreset");
      chk("midreset_rel_b", rel_b, 0);
      rst = 1'b0;
      s = scan_no;
      exp_evt(3, 1'b0, 4'd3, s + 3);
      exp_evt(3, 1'b1, 4'd3, s + 6);
      hold(16'h0008, 3);
      hold(16'h0000, 3);
      hold(16'h0000, 1);

      repeat (5) settle();
      chk("queue_a_drained", q0.size(), 0);
      chk("queue_b_drained", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
